// File: rtl/reorder_buffer_if.sv
// Issue / writeback / query / commit bundle between the reorder buffer and its pipeline.
// Pure wiring; no latency of its own.
// Backpressure is carried by rdy_in (global pause) and rob_full (issue stall).
interface reorder_buffer_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 rdy_in;
    logic                 flush_in;

    logic                 issue_valid;
    logic [4:0]           issue_rd;
    logic                 issue_ready;
    logic [31:0]          issue_value;
    logic [ROB_WIDTH-1:0] issue_tag;
    logic                 rob_full;

    logic                 cdb_valid;
    logic [ROB_WIDTH-1:0] cdb_tag;
    logic [31:0]          cdb_value;

    logic [ROB_WIDTH-1:0] query_tag_1;
    logic [ROB_WIDTH-1:0] query_tag_2;
    logic                 query_ready_1;
    logic                 query_ready_2;
    logic [31:0]          query_value_1;
    logic [31:0]          query_value_2;

    logic                 commit_signal;
    logic [ROB_WIDTH-1:0] commit_rd_tag;
    logic [31:0]          commit_rd_value;
    logic [4:0]           commit_rd_id;

    modport master (
        output rdy_in, flush_in,
        output issue_valid, issue_rd, issue_ready, issue_value,
        input  issue_tag, rob_full,
        output cdb_valid, cdb_tag, cdb_value,
        output query_tag_1, query_tag_2,
        input  query_ready_1, query_ready_2, query_value_1, query_value_2,
        input  commit_signal, commit_rd_tag, commit_rd_value, commit_rd_id
    );

    modport slave (
        input  rdy_in, flush_in,
        input  issue_valid, issue_rd, issue_ready, issue_value,
        output issue_tag, rob_full,
        input  cdb_valid, cdb_tag, cdb_value,
        input  query_tag_1, query_tag_2,
        output query_ready_1, query_ready_2, query_value_1, query_value_2,
        output commit_signal, commit_rd_tag, commit_rd_value, commit_rd_id
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order issue/commit, out-of-order CDB writeback, operand forwarding.
// Latency: issue-to-commit >= 1 cycle; CDB result commits no earlier than the next cycle.
// Backpressure: rob_full stalls issue; rdy_in low freezes all state.
module reorder_buffer #(
    parameter int ROB_WIDTH = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    reorder_buffer_if.slave    rob
);
    localparam int DEPTH = 1 << ROB_WIDTH;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [4:0]  rd;
        logic [31:0] value;
    } rob_entry_t;

    rob_entry_t           entries [DEPTH];
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;

    logic full;
    logic commit_vld;
    logic do_issue;
    logic do_wb;
    logic do_commit;

    assign full       = (count == (ROB_WIDTH+1)'(DEPTH));
    assign commit_vld = ~rob.flush_in & entries[head].busy & entries[head].ready;

    assign do_issue  = rob.rdy_in & rob.issue_valid & ~full & ~rob.flush_in;
    assign do_wb     = rob.rdy_in & rob.cdb_valid & ~rob.flush_in
                     & entries[rob.cdb_tag].busy & ~entries[rob.cdb_tag].ready;
    assign do_commit = rob.rdy_in & commit_vld;

    assign rob.rob_full        = full;
    assign rob.issue_tag       = tail;
    assign rob.commit_signal   = commit_vld;
    assign rob.commit_rd_tag   = head;
    assign rob.commit_rd_value = entries[head].value;
    assign rob.commit_rd_id    = entries[head].rd;

    // A result on the CDB this cycle wins over the stored entry for both operand ports.
    always_comb begin
        rob.query_ready_1 = entries[rob.query_tag_1].busy & entries[rob.query_tag_1].ready;
        rob.query_value_1 = entries[rob.query_tag_1].value;
        if (rob.cdb_valid && (rob.cdb_tag == rob.query_tag_1)) begin
            rob.query_ready_1 = 1'b1;
            rob.query_value_1 = rob.cdb_value;
        end
    end

    always_comb begin
        rob.query_ready_2 = entries[rob.query_tag_2].busy & entries[rob.query_tag_2].ready;
        rob.query_value_2 = entries[rob.query_tag_2].value;
        if (rob.cdb_valid && (rob.cdb_tag == rob.query_tag_2)) begin
            rob.query_ready_2 = 1'b1;
            rob.query_value_2 = rob.cdb_value;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (rob.rdy_in) begin
            if (rob.flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    entries[i].busy  <= 1'b0;
                    entries[i].ready <= 1'b0;
                end
            end else begin
                // Issue targets a free slot and writeback a busy one, so they never collide.
                if (do_issue) begin
                    entries[tail].busy  <= 1'b1;
                    entries[tail].ready <= rob.issue_ready;
                    entries[tail].rd    <= rob.issue_rd;
                    entries[tail].value <= rob.issue_ready ? rob.issue_value : 32'd0;
                    tail                <= tail + 1'b1;
                end
                if (do_wb) begin
                    entries[rob.cdb_tag].ready <= 1'b1;
                    entries[rob.cdb_tag].value <= rob.cdb_value;
                end
                if (do_commit) begin
                    entries[head].busy <= 1'b0;
                    head               <= head + 1'b1;
                end
                case ({do_issue, do_commit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule
